key_debounce: RTL

Conditioning stage between the raw push-button pin and the button-driven sequencer. It synchronises the asynchronous, active-low `key1` pin into the `clk12MHz` domain and debounces it with a four-state FSM. Outputs are a clean active-high level plus single-cycle press, release and long-press pulses. The sequencer consumes `press_pulse` in place of raw `~key1`, so one physical press starts exactly one run.

---
 rtl/key_debounce.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Synchronises the active-low, bouncy key1 pin into clk12MHz and
//            debounces it. Produces a clean held level plus single-cycle
//            press, release and long-press strobes, and a press counter.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int CNT_W           = 24
) (
  input  logic       clk12MHz,
  input  logic       rst,
  input  logic       key1,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  // Terminal values of the two counters, sized to the counter width.
  localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_long_prev = CNT_W'(LONG_CYCLES - 2);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_zero  = '0;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] w_db_cnt_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic             r_long_fired;
  logic             w_long_fired_nxt;
  logic             w_hold_run;
  logic             r_pressed;
  logic             w_pressed_nxt;
  logic             r_press_pulse;
  logic             w_press_pulse_nxt;
  logic             r_release_pulse;
  logic             w_release_pulse_nxt;
  logic             r_long_pulse;
  logic             w_long_pulse_nxt;
  logic [7:0]       r_press_count;
  logic [7:0]       w_press_count_nxt;

  // Two-flop synchroniser; resets to the released level (high).
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key1;
      r_sync2 <= r_sync1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_db_cnt        <= c_cnt_zero;
      r_hold_cnt      <= c_cnt_zero;
      r_long_fired    <= 1'b0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      r_press_count   <= 8'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_db_cnt        <= w_db_cnt_nxt;
      r_hold_cnt      <= w_hold_cnt_nxt;
      r_long_fired    <= w_long_fired_nxt;
      r_pressed       <= w_pressed_nxt;
      r_press_pulse   <= w_press_pulse_nxt;
      r_release_pulse <= w_release_pulse_nxt;
      r_long_pulse    <= w_long_pulse_nxt;
      r_press_count   <= w_press_count_nxt;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    w_state_nxt         = r_state;
    w_db_cnt_nxt        = r_db_cnt;
    w_hold_cnt_nxt      = r_hold_cnt;
    w_long_fired_nxt    = r_long_fired;
    w_hold_run          = 1'b0;
    w_press_pulse_nxt   = 1'b0;
    w_release_pulse_nxt = 1'b0;
    w_long_pulse_nxt    = 1'b0;
    w_press_count_nxt   = r_press_count;

    case (r_state)
      ST_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt  = ST_PRESS_WAIT;
          w_db_cnt_nxt = c_cnt_zero;
        end
      end
      ST_PRESS_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = ST_IDLE;
        end else if (r_db_cnt == c_db_last) begin
          w_state_nxt       = ST_HELD;
          w_press_pulse_nxt = 1'b1;
          w_press_count_nxt = r_press_count + 8'd1;
          w_hold_cnt_nxt    = c_cnt_zero;
          w_long_fired_nxt  = 1'b0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + c_cnt_one;
        end
      end
      ST_HELD: begin
        w_hold_run = 1'b1;
        if (r_sync2) begin
          w_state_nxt  = ST_RELEASE_WAIT;
          w_db_cnt_nxt = c_cnt_zero;
        end
      end
      ST_RELEASE_WAIT: begin
        w_hold_run = 1'b1;
        if (!r_sync2) begin
          w_state_nxt = ST_HELD;
        end else if (r_db_cnt == c_db_last) begin
          // The release edge ends the press: no long strobe on the same
          // cycle, so the pulses can never overlap.
          w_state_nxt         = ST_IDLE;
          w_release_pulse_nxt = 1'b1;
          w_hold_run          = 1'b0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Hold timer saturates at its terminal count; the strobe fires on the
    // cycle the terminal count is reached, once per press.
    if (w_hold_run && (r_hold_cnt != c_long_last)) begin
      w_hold_cnt_nxt = r_hold_cnt + c_cnt_one;
      if ((r_hold_cnt == c_long_prev) && !r_long_fired) begin
        w_long_pulse_nxt = 1'b1;
        w_long_fired_nxt = 1'b1;
      end
    end

    w_pressed_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_WAIT);
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign long_pulse    = r_long_pulse;
  assign press_count   = r_press_count;

endmodule
`default_nettype wire
